dds_tuning_calc: RTL and testbench



---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_tuning_calc_if.sv | 22 ++
 rtl/serial_udiv.sv | 74 +++++++
 rtl/dds_tuning_calc.sv | 159 +++++++++++++++
 tb/tb_dds_tuning_calc.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and sizing helpers for the DDS tuning-word calculator.
package dds_pkg;

    localparam int unsigned CLOCK_FREQUENCY_DEF = 100_000_000;
    localparam int unsigned ACC_WIDTH_DEF       = 8;
    localparam int unsigned FREQ_WIDTH_DEF      = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_DIV    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Largest increment below Nyquist for a 2^acc_w entry phase wheel.
    function automatic int unsigned tw_max(input int unsigned acc_w);
        return (32'd1 << (acc_w - 32'd1)) - 32'd1;
    endfunction

    // Headroom bit lets the shifted remainder reach 2*divisor-1 without overflow.
    function automatic int unsigned rem_width(input int unsigned cf);
        return 32'($clog2(cf)) + 32'd1;
    endfunction

    localparam int unsigned REM_WIDTH_DEF = rem_width(CLOCK_FREQUENCY_DEF);

endpackage

// File: rtl/dds_tuning_calc_if.sv
// Request/response bundle between a frequency requester and dds_tuning_calc.
interface dds_tuning_calc_if #(
    parameter int unsigned FREQ_WIDTH = dds_pkg::FREQ_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = dds_pkg::ACC_WIDTH_DEF
);
    logic                  start_i;
    logic [FREQ_WIDTH-1:0] desired_freq_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ACC_WIDTH-1:0]  tuning_word_o;
    logic                  range_err_o;

    modport master (
        output start_i, desired_freq_i,
        input  busy_o, done_o, tuning_word_o, range_err_o
    );

    modport slave (
        input  start_i, desired_freq_i,
        output busy_o, done_o, tuning_word_o, range_err_o
    );
endinterface

// File: rtl/serial_udiv.sv
// Restoring unsigned divider by a constant divisor, one quotient bit per step, MSB first.
module serial_udiv #(
    parameter int unsigned DIVIDEND_W = 40,
    parameter int unsigned REM_W      = 28,
    parameter int unsigned DIVISOR    = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic                  step_i,
    output logic                  last_o,
    output logic [DIVIDEND_W-1:0] quotient_o,
    output logic [REM_W-1:0]      remainder_o
);
    localparam int unsigned    CNT_W = (DIVIDEND_W > 32'd1) ? 32'($clog2(DIVIDEND_W)) : 32'd1;
    localparam logic [REM_W-1:0] DIV_C = REM_W'(DIVISOR);

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DIVIDEND_W-1:0] shreg_q, shreg_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic [REM_W-1:0]      trial_c;
    logic                  fits_c;

    always_comb begin
        trial_c = {rem_q[REM_W-2:0], shreg_q[DIVIDEND_W-1]};
        fits_c  = (trial_c >= DIV_C);
    end

    always_comb begin
        shreg_d = shreg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (clr_i) begin
            shreg_d = '0;
            rem_d   = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (load_i) begin
            shreg_d = dividend_i;
            rem_d   = '0;
            cnt_d   = CNT_W'(DIVIDEND_W - 32'd1);
            last_d  = (DIVIDEND_W == 32'd1);
        end else if (step_i) begin
            rem_d   = fits_c ? (trial_c - DIV_C) : trial_c;
            shreg_d = {shreg_q[DIVIDEND_W-2:0], fits_c};
            cnt_d   = cnt_q - CNT_W'(1);
            last_d  = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign last_o      = last_q;
    assign quotient_o  = shreg_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/dds_tuning_calc.sv
// Converts a frequency request in Hz into a DDS phase increment via a serial divider.
// Define DDS_TUNE_ROUND_EN to round the quotient to nearest instead of truncating.
module dds_tuning_calc
    import dds_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEF,
    parameter int unsigned ACC_WIDTH       = ACC_WIDTH_DEF,
    parameter int unsigned FREQ_WIDTH      = FREQ_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    dds_tuning_calc_if.slave   bus
);
    localparam int unsigned N      = FREQ_WIDTH + ACC_WIDTH;
    localparam int unsigned NQ     = N + 32'd1;
    localparam int unsigned REM_W  = rem_width(CLOCK_FREQUENCY);
    localparam int unsigned TW_MAX = tw_max(ACC_WIDTH);

    localparam logic [NQ-1:0]        TW_MAX_Q = NQ'(TW_MAX);
    localparam logic [ACC_WIDTH-1:0] TW_SAT   = ACC_WIDTH'(TW_MAX);
    localparam logic [63:0]          CF64     = 64'(CLOCK_FREQUENCY);

`ifdef DDS_TUNE_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
    logic                   sat_q, sat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ACC_WIDTH-1:0]   tw_q, tw_d;
    logic                   rerr_q, rerr_d;

    logic                   div_clr_c, div_load_c, div_step_c;
    logic                   div_last;
    logic [N-1:0]           div_quot;
    logic [REM_W-1:0]       div_rem;

    logic                   accept_c;
    logic                   too_fast_c;
    logic                   round_up_c;
    logic [NQ-1:0]          q_rnd_c;
    logic [ACC_WIDTH-1:0]   tw_norm_c;

    serial_udiv #(
        .DIVIDEND_W (N),
        .REM_W      (REM_W),
        .DIVISOR    (CLOCK_FREQUENCY)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (div_clr_c),
        .load_i      (div_load_c),
        .dividend_i  ({freq_q, ACC_WIDTH'(0)}),
        .step_i      (div_step_c),
        .last_o      (div_last),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

    // A start overlapping the done pulse is dropped so each request yields exactly one done.
    always_comb begin
        accept_c   = bus.start_i && !done_q;
        too_fast_c = ((64'(freq_q) << 1) >= CF64);
        round_up_c = ROUND_EN && ((64'(div_rem) << 1) >= CF64);
        q_rnd_c    = {1'b0, div_quot} + NQ'(round_up_c);
        tw_norm_c  = (q_rnd_c > TW_MAX_Q) ? TW_SAT : ACC_WIDTH'(q_rnd_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c) state_d = ST_CHECK;
            ST_CHECK:  state_d = too_fast_c ? ST_FINISH : ST_DIV;
            ST_DIV:    if (div_last) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        freq_d     = freq_q;
        sat_d      = sat_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        tw_d       = tw_q;
        rerr_d     = rerr_q;
        div_clr_c  = 1'b0;
        div_load_c = 1'b0;
        div_step_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    freq_d    = bus.desired_freq_i;
                    sat_d     = 1'b0;
                    div_clr_c = 1'b1;
                end
            end
            ST_CHECK: begin
                busy_d = 1'b1;
                if (too_fast_c) begin
                    sat_d = 1'b1;
                end else begin
                    div_load_c = 1'b1;
                end
            end
            ST_DIV: begin
                busy_d     = 1'b1;
                div_step_c = 1'b1;
            end
            ST_FINISH: begin
                done_d = 1'b1;
                if (sat_q) begin
                    tw_d   = TW_SAT;
                    rerr_d = 1'b1;
                end else begin
                    tw_d   = tw_norm_c;
                    rerr_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q <= '0;
            sat_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tw_q   <= '0;
            rerr_q <= 1'b0;
        end else begin
            freq_q <= freq_d;
            sat_q  <= sat_d;
            busy_q <= busy_d;
            done_q <= done_d;
            tw_q   <= tw_d;
            rerr_q <= rerr_d;
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.tuning_word_o = tw_q;
    assign bus.range_err_o   = rerr_q;

endmodule

// File: tb/tb_dds_tuning_calc.sv
// Randomized self-checking bench for dds_tuning_calc against an arithmetic reference model.
module tb_dds_tuning_calc;
    localparam longint CF     = 100_000_000;
    localparam int     ACC    = 8;
    localparam int     FW     = 32;
    localparam int     NBITS  = FW + ACC;
    localparam longint TWMAX  = (64'd1 << (ACC - 1)) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dds_tuning_calc_if #(.FREQ_WIDTH(FW), .ACC_WIDTH(ACC)) bus ();

    dds_tuning_calc #(
        .CLOCK_FREQUENCY (CF),
        .ACC_WIDTH       (ACC),
        .FREQ_WIDTH      (FW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: tuning_word = f * 2^ACC / CF, saturated at Nyquist and clamped to TWMAX.
    task automatic model(input longint f, output longint tw, output longint err, output int lat);
        longint num, q, r;
        if (2 * f >= CF) begin
            tw  = TWMAX;
            err = 1;
            lat = 2;
        end else begin
            num = f * (64'd1 << ACC);
            q   = num / CF;
            r   = num % CF;
`ifdef DDS_TUNE_ROUND_EN
            if (2 * r >= CF) q = q + 1;
`endif
            tw  = (q > TWMAX) ? TWMAX : q;
            err = 0;
            lat = NBITS + 2;
        end
    endtask

    task automatic run_req(input longint f, input bit noisy);
        longint tw, err;
        int     lat, edges, seen;
        model(f, tw, err, lat);
        @(negedge clk);
        bus.start_i        = 1'b1;
        bus.desired_freq_i = 32'(f);
        @(negedge clk);
        bus.start_i = 1'b0;
        edges       = 0;
        if (noisy) bus.desired_freq_i = $urandom;
        while (!bus.done_o && edges < lat + 10) begin
            @(negedge clk);
            edges++;
            if (edges == 1) check("busy_rise", longint'(bus.busy_o), 1);
            if (noisy) begin
                bus.start_i        = 1'($urandom_range(0, 1));
                bus.desired_freq_i = $urandom;
            end
        end
        check("latency", edges, lat);
        check("tuning_word", longint'(bus.tuning_word_o), tw);
        check("range_err", longint'(bus.range_err_o), err);
        check("busy_at_done", longint'(bus.busy_o), 0);
        bus.start_i = noisy;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("done_one_cycle", longint'(bus.done_o), 0);
        check("tw_held", longint'(bus.tuning_word_o), tw);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy_o || bus.done_o) seen = 1;
        end
        check("stray_start_ignored", seen, 0);
    endtask

    initial begin
        int seen;
        longint f;
        rst                = 1'b1;
        bus.start_i        = 1'b0;
        bus.desired_freq_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(bus.busy_o), 0);
        check("rst_done", longint'(bus.done_o), 0);
        check("rst_tw", longint'(bus.tuning_word_o), 0);
        check("rst_rerr", longint'(bus.range_err_o), 0);
        rst = 1'b0;
        @(negedge clk);

        run_req(5_078_125, 1'b0);
        run_req(5_000_000, 1'b0);
        run_req(0, 1'b1);
        run_req(49_999_999, 1'b0);
        run_req(50_000_000, 1'b0);

        // Abort a computation with reset at its 20th cycle.
        bus.start_i        = 1'b1;
        bus.desired_freq_i = 32'd5_078_125;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", longint'(bus.busy_o), 0);
        check("abort_tw", longint'(bus.tuning_word_o), 0);
        check("abort_rerr", longint'(bus.range_err_o), 0);
        rst  = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.done_o) seen = 1;
        end
        check("abort_no_done", seen, 0);
        run_req(390_625, 1'b0);

        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) f = 49_999_990 + longint'($urandom_range(0, 20));
            else            f = longint'($urandom_range(0, 60_000_000));
            run_req(f, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
